// File: rtl/muldiv_pkg.sv
// Shared types for the M-extension multiply/divide unit.
// Op codes follow the RISC-V funct3 encoding.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/iter_div_core.sv
// Unsigned restoring divider, one quotient bit per clock.
// The first step is taken on the start edge itself, so o_done rises XLEN edges after start.
module iter_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_abort,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_divisor;
    logic [CW-1:0]   r_count;
    logic            r_active;

    logic [XLEN-1:0] w_rem_src;
    logic [XLEN-1:0] w_quo_src;
    logic [XLEN-1:0] w_dvs;
    logic [XLEN:0]   w_partial;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;

    always_comb begin
        w_rem_src = i_start ? '0         : r_rem;
        w_quo_src = i_start ? i_dividend : r_quo;
        w_dvs     = i_start ? i_divisor  : r_divisor;
        w_partial = {w_rem_src, w_quo_src[XLEN-1]};
        w_diff    = w_partial - {1'b0, w_dvs};
        // A clear borrow bit means the trial subtraction fits: keep it, shift in a 1.
        if (!w_diff[XLEN]) begin
            w_rem_next = w_diff[XLEN-1:0];
            w_quo_next = {w_quo_src[XLEN-2:0], 1'b1};
        end else begin
            w_rem_next = w_partial[XLEN-1:0];
            w_quo_next = {w_quo_src[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_active  <= 1'b0;
        end else if (i_start) begin
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next;
            r_divisor <= i_divisor;
            r_count   <= CW'(1);
            r_active  <= 1'b1;
        end else if (r_active) begin
            if (r_count == LAST) begin
                r_active <= 1'b0;
            end else begin
                r_rem   <= w_rem_next;
                r_quo   <= w_quo_next;
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_done      = r_active && (r_count == LAST);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit with valid/ready handshakes, flush and tag passthrough.
// Divide-by-zero and signed overflow are resolved at accept without running the divider.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e r_state, w_state_next;

    op_e              r_op;
    logic [XLEN-1:0]  r_a, r_b;
    logic [TAG_W-1:0] r_tag;
    logic             r_neg_q, r_neg_r;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_out_tag;

    op_e             w_op;
    logic            w_accept;
    logic            w_div_signed;
    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_core_start, w_core_done;
    logic [XLEN-1:0] w_core_q, w_core_r;
    logic [XLEN-1:0] w_div_res;

    logic                   w_sa, w_sb;
    logic signed [XLEN:0]   w_a_ext, w_b_ext;
    logic signed [2*XLEN+1:0] w_prod;

    assign w_op     = op_e'(op);
    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result   = r_result;
    assign out_tag  = r_out_tag;
    assign w_accept = in_valid && in_ready && !flush;

    // DIV/REM have op[0]=0; the remainder ops have op[1]=1.
    always_comb begin
        w_div_signed  = is_div(w_op) && !w_op[0];
        w_a_neg       = w_div_signed && operand_a[XLEN-1];
        w_b_neg       = w_div_signed && operand_b[XLEN-1];
        w_a_mag       = w_a_neg ? -operand_a : operand_a;
        w_b_mag       = w_b_neg ? -operand_b : operand_b;
        w_b_zero      = (operand_b == '0);
        w_ovf         = w_div_signed && (operand_a == MOST_NEG) && (operand_b == '1);
        w_special     = is_div(w_op) && (w_b_zero || w_ovf);
        w_special_res = '0;
        if (w_op[1]) w_special_res = w_b_zero ? operand_a : '0;
        else         w_special_res = w_b_zero ? '1 : operand_a;
        w_core_start  = w_accept && is_div(w_op) && !w_special;
    end

    iter_div_core #(.XLEN(XLEN)) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_abort     (flush),
        .i_start     (w_core_start),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .o_done      (w_core_done),
        .o_quotient  (w_core_q),
        .o_remainder (w_core_r)
    );

    always_comb begin
        w_div_res = '0;
        if (r_op[1]) w_div_res = r_neg_r ? -w_core_r : w_core_r;
        else         w_div_res = r_neg_q ? -w_core_q : w_core_q;
    end

    always_comb begin
        w_sa    = (r_op != OP_MULHU);
        w_sb    = (r_op == OP_MUL) || (r_op == OP_MULH);
        w_a_ext = {w_sa && r_a[XLEN-1], r_a};
        w_b_ext = {w_sb && r_b[XLEN-1], r_b};
        w_prod  = (2*XLEN+2)'(w_a_ext) * (2*XLEN+2)'(w_b_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) begin
                if (!is_div(w_op))  w_state_next = S_MUL;
                else if (w_special) w_state_next = S_DONE;
                else                w_state_next = S_DIV;
            end
            S_MUL:  w_state_next = S_DONE;
            S_DIV:  if (w_core_done) w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_a       <= '0;
            r_b       <= '0;
            r_tag     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_out_tag <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= w_op;
                r_a     <= operand_a;
                r_b     <= operand_b;
                r_tag   <= in_tag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                if (w_special) begin
                    r_result  <= w_special_res;
                    r_out_tag <= in_tag;
                end
            end
            if (r_state == S_MUL && !flush) begin
                r_result  <= (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
                r_out_tag <= r_tag;
            end
            if (r_state == S_DIV && w_core_done && !flush) begin
                r_result  <= w_div_res;
                r_out_tag <= r_tag;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count edges (accept edge = 1) until out_valid, optionally consume.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input bit consume,
                          output int lat, output logic [31:0] res, output logic [4:0] rtag);
        op = o; operand_a = a; operand_b = b; in_tag = t; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; operand_a = '0; operand_b = '0; in_tag = '0; op = 3'd0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = result;
        rtag = out_tag;
        if (consume && out_valid) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got %h exp 0", result); end
        total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_out_tag got %h exp 0", out_tag); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_mul();
        logic [2:0]  ops  [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] as   [4] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs   [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps [4] = '{32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        int lat; logic [31:0] res; logic [4:0] rtag;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 3), 1'b1, lat, res, rtag);
            total++; if (res !== exps[i]) begin bad++; $display("FAIL mul_result op=%0d got %h exp %h", ops[i], res, exps[i]); end
            total++; if (lat !== 2) begin bad++; $display("FAIL mul_latency op=%0d got %0d exp 2", ops[i], lat); end
            total++; if (rtag !== 5'(i + 3)) begin bad++; $display("FAIL mul_tag op=%0d got %0d exp %0d", ops[i], rtag, i + 3); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as   [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exps [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        int lat; logic [31:0] res; logic [4:0] rtag;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 10), 1'b1, lat, res, rtag);
            total++; if (res !== exps[i]) begin bad++; $display("FAIL div_result op=%0d got %h exp %h", ops[i], res, exps[i]); end
            total++; if (lat !== 33) begin bad++; $display("FAIL div_latency op=%0d got %0d exp 33", ops[i], lat); end
            total++; if (rtag !== 5'(i + 10)) begin bad++; $display("FAIL div_tag op=%0d got %0d exp %0d", ops[i], rtag, i + 10); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops  [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int lat; logic [31:0] res; logic [4:0] rtag;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 20), 1'b1, lat, res, rtag);
            total++; if (res !== exps[i]) begin bad++; $display("FAIL special_result op=%0d got %h exp %h", ops[i], res, exps[i]); end
            total++; if (lat !== 1) begin bad++; $display("FAIL special_latency op=%0d got %0d exp 1", ops[i], lat); end
            total++; if (rtag !== 5'(i + 20)) begin bad++; $display("FAIL special_tag op=%0d got %0d exp %0d", ops[i], rtag, i + 20); end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] res; logic [4:0] rtag;
        run_op(3'd5, 32'd100, 32'd7, 5'd9, 1'b0, lat, res, rtag);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_wait_valid got %b exp 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (result !== 32'd14) begin bad++; $display("FAIL bp_result cyc=%0d got %h exp %h", i, result, 32'd14); end
            total++; if (out_tag !== 5'd9) begin bad++; $display("FAIL bp_tag cyc=%0d got %0d exp 9", i, out_tag); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got %b exp 0", i, in_ready); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy cyc=%0d got %b exp 1", i, busy); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        int seen = 0;
        int lat; logic [31:0] res; logic [4:0] rtag;
        op = 3'd4; operand_a = 32'd1000; operand_b = 32'd3; in_tag = 5'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_valid got %0d exp 0", seen); end
        // Flush beats a simultaneous request.
        op = 3'd0; operand_a = 32'd2; operand_b = 32'd3; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_blocks_accept got %b exp 0", busy); end
        run_op(3'd4, 32'd9, 32'd3, 5'd7, 1'b1, lat, res, rtag);
        total++; if (res !== 32'd3) begin bad++; $display("FAIL flush_next_div got %h exp 3", res); end
        total++; if (lat !== 33) begin bad++; $display("FAIL flush_next_latency got %0d exp 33", lat); end
    endtask

    task automatic test_reset_mid();
        op = 3'd5; operand_a = 32'd77; operand_b = 32'd5; in_tag = 5'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        op = 3'd0; operand_a = 32'd3; operand_b = 32'd4; in_valid = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rstmid_result got %h exp 0", result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready); end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_no_accept got %b exp 0", busy); end
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stays_idle got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
